// File: rtl/axi_wr_master.sv
// AXI4 write-channel manager: takes one burst command at a time, checks it against AXI4
// burst rules, drives AW, streams W with generated strobes/last and reports BRESP on done.
module axi_wr_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int unsigned MaxSize = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LaneMask = ADDR_WIDTH'(STRB_WIDTH - 1);
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] BurstRsvd  = 2'b11;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [2:0] {StIdle, StErr, StAw, StW, StB, StDone} state_e;

    state_e                state_q;
    logic [7:0]            beat_cnt_q;
    logic [ADDR_WIDTH-1:0] beat_addr_q;
    logic [ADDR_WIDTH-1:0] next_addr;

    logic [ADDR_WIDTH-1:0] cmd_mask;
    logic [31:0]           incr_end;
    logic                  cmd_illegal;

    logic [ADDR_WIDTH-1:0] nbytes;
    logic [ADDR_WIDTH-1:0] size_mask;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    int unsigned           lane;
    int unsigned           alane;
    int unsigned           nb_int;

    // Legality of the command currently presented; only used on acceptance.
    always_comb begin
        cmd_mask    = (ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1);
        incr_end    = (32'(cmd_addr[11:0]) & ~32'(cmd_mask))
                    + ((32'(cmd_len) + 32'd1) << cmd_size);
        cmd_illegal = 1'b0;
        if (cmd_burst == BurstRsvd) cmd_illegal = 1'b1;
        if (32'(cmd_size) > MaxSize) cmd_illegal = 1'b1;
        if (cmd_burst == BurstWrap && !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
            cmd_illegal = 1'b1;
        end
        if (cmd_burst == BurstWrap && (cmd_addr & cmd_mask) != '0) cmd_illegal = 1'b1;
        if (cmd_burst == BurstIncr && incr_end > 32'd4096) cmd_illegal = 1'b1;
    end

    always_comb begin
        nbytes    = ADDR_WIDTH'(1) << awsize;
        size_mask = nbytes - ADDR_WIDTH'(1);
        wrap_mask = ((ADDR_WIDTH'(awlen) + ADDR_WIDTH'(1)) << awsize) - ADDR_WIDTH'(1);
        case (awburst)
            BurstIncr: next_addr = (beat_addr_q & ~size_mask) + nbytes;
            BurstWrap: next_addr = (beat_addr_q & ~wrap_mask) | ((beat_addr_q + nbytes) & wrap_mask);
            default:   next_addr = beat_addr_q;
        endcase
    end

    // Active lanes run from the beat's own byte lane up to the end of its aligned slot.
    always_comb begin
        lane   = 32'(beat_addr_q & LaneMask);
        alane  = 32'(beat_addr_q & ~size_mask & LaneMask);
        nb_int = 32'd1 << awsize;
        wstrb  = '0;
        for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
            wstrb[i] = (state_q == StW) && (i >= lane) && (i < alane + nb_int);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            done        <= 1'b0;
            done_resp   <= 2'b00;
            beat_cnt_q  <= '0;
            beat_addr_q <= '0;
            awaddr      <= '0;
            awlen       <= '0;
            awsize      <= '0;
            awburst     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        awaddr      <= cmd_addr;
                        awlen       <= cmd_len;
                        awsize      <= cmd_size;
                        awburst     <= cmd_burst;
                        beat_addr_q <= cmd_addr;
                        beat_cnt_q  <= '0;
                        if (cmd_illegal) begin
                            state_q   <= StErr;
                            done      <= 1'b1;
                            done_resp <= RespSlverr;
                        end else begin
                            state_q <= StAw;
                        end
                    end
                end
                StAw: begin
                    if (awready) state_q <= StW;
                end
                StW: begin
                    if (wr_valid && wready) begin
                        if (beat_cnt_q == awlen) begin
                            state_q <= StB;
                        end else begin
                            beat_cnt_q  <= beat_cnt_q + 8'd1;
                            beat_addr_q <= next_addr;
                        end
                    end
                end
                StB: begin
                    if (bvalid) begin
                        state_q   <= StDone;
                        done      <= 1'b1;
                        done_resp <= bresp;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready = (state_q == StIdle) && !rst;
    assign awvalid   = (state_q == StAw);
    assign wvalid    = (state_q == StW) && wr_valid;
    assign wr_ready  = (state_q == StW) && wready;
    assign wlast     = (state_q == StW) && (beat_cnt_q == awlen);
    assign wdata     = wr_data;
    assign bready    = (state_q == StB);

endmodule

// File: tb/tb_axi_wr_master.sv
// Scoreboard bench for axi_wr_master: stimulus pushes expected AW/W/done items computed from
// burst arithmetic; a negedge monitor pops and compares whenever the DUT hands something over.
module tb_axi_wr_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic [2:0]    cmd_size = '0;
    logic [1:0]    cmd_burst = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          done;
    logic [1:0]    done_resp;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready = 1'b0;
    logic [1:0]    bresp = 2'b00;
    logic          bvalid = 1'b0;
    logic          bready;

    axi_wr_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .done(done), .done_resp(done_resp),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } aw_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } w_t;
    typedef struct packed {
        logic [1:0] resp;
        logic       illegal;
    } d_t;

    aw_t exp_aw[$];
    w_t  exp_w[$];
    d_t  exp_d[$];

    int checks = 0;
    int errors = 0;
    int aw_dly = 0;
    int wr_pct = 100;
    int b_dly = 0;
    logic [1:0] cur_bresp = 2'b00;
    int accept_cyc = -10;
    int b_cyc = -10;
    int ready_chk = -10;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake (cycle %0d)", name, cyc);
        finish_run();
    endtask

    // Reference model: AXI4 burst rules in plain arithmetic.
    function automatic bit model_legal(int unsigned a, int unsigned len, int unsigned size,
                                       int unsigned burst);
        int unsigned nb = 32'd1 << size;
        if (burst == 3) return 1'b0;
        if (nb > SW) return 1'b0;
        if (burst == 2) begin
            if (len != 1 && len != 3 && len != 7 && len != 15) return 1'b0;
            if (a % nb != 0) return 1'b0;
        end
        if (burst == 1 && (a % 4096) - (a % nb) + (len + 1) * nb > 4096) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [SW-1:0] model_strb(int unsigned a, int unsigned nb);
        int unsigned lo = a % SW;
        int unsigned hi = (a - a % nb) % SW + nb;
        logic [SW-1:0] s = '0;
        for (int unsigned i = 0; i < SW; i++) if (i >= lo && i < hi) s[i] = 1'b1;
        return s;
    endfunction

    function automatic int unsigned model_next(int unsigned a, int unsigned nb, int unsigned len,
                                               int unsigned burst);
        int unsigned bound = (len + 1) * nb;
        int unsigned base = a - a % bound;
        if (burst == 0) return a;
        if (burst == 1) return a - a % nb + nb;
        return base + (a + nb - base) % bound;
    endfunction

    task automatic do_abort();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_valid = 1'b1;
        exp_aw.delete();
        exp_w.delete();
        exp_d.delete();
        @(negedge clk);
        check("abort_awvalid", 64'(awvalid), 0);
        check("abort_wvalid", 64'(wvalid), 0);
        check("abort_bready", 64'(bready), 0);
        check("abort_done", 64'(done), 0);
        check("abort_cmd_ready", 64'(cmd_ready), 1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input int unsigned a, input int unsigned len, input int unsigned size,
                            input int unsigned burst, input logic [1:0] resp, input int gap_max,
                            input int abort_after);
        bit legal = model_legal(a, len, size, burst);
        int unsigned ba = a;
        int unsigned nb = 32'd1 << size;
        logic [DW-1:0] data[$];
        aw_t e;
        w_t w;
        d_t d;
        int n;
        if (legal) begin
            e.addr = a;
            e.len = 8'(len);
            e.size = 3'(size);
            e.burst = 2'(burst);
            exp_aw.push_back(e);
            for (int unsigned i = 0; i <= len; i++) begin
                w.data = $urandom;
                w.strb = model_strb(ba, nb);
                w.last = (i == len);
                data.push_back(w.data);
                exp_w.push_back(w);
                ba = model_next(ba, nb, len, burst);
            end
            d.resp = resp;
            d.illegal = 1'b0;
        end else begin
            d.resp = 2'b10;
            d.illegal = 1'b1;
        end
        exp_d.push_back(d);
        cur_bresp = resp;

        cmd_addr = a;
        cmd_len = 8'(len);
        cmd_size = 3'(size);
        cmd_burst = 2'(burst);
        cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 1000);
        if (!cmd_ready) timeout_fail("cmd_accept");
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;

        if (legal) begin
            for (int unsigned i = 0; i <= len; i++) begin
                if (int'(i) == abort_after) begin
                    do_abort();
                    return;
                end
                wr_valid = 1'b0;
                repeat ($urandom_range(gap_max, 0)) begin
                    @(posedge clk);
                    #1;
                end
                wr_valid = 1'b1;
                wr_data = data[i];
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!wr_ready && n < 1000);
                if (!wr_ready) timeout_fail("w_beat");
                @(posedge clk);
                #1;
            end
            wr_valid = 1'b0;
        end

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 1000);
        if (!done) timeout_fail("done_wait");
        @(posedge clk);
        #1;
    endtask

    // Subordinate-side responders.
    initial begin
        int aw_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!awvalid) begin
                awready = 1'b0;
                aw_cnt = 0;
            end else if (aw_cnt < aw_dly) begin
                awready = 1'b0;
                aw_cnt++;
            end else begin
                awready = 1'b1;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        wready = ($urandom_range(99, 0) < 32'(wr_pct));
    end

    initial begin
        int b_cnt = 0;
        logic b_hs;
        forever begin
            @(negedge clk);
            b_hs = bvalid && bready;
            @(posedge clk);
            #1;
            if (b_hs || !bready) begin
                bvalid = 1'b0;
                b_cnt = 0;
            end else if (b_cnt < b_dly) begin
                b_cnt++;
            end else begin
                bvalid = 1'b1;
                bresp = cur_bresp;
            end
        end
    end

    // Monitor: compares every DUT hand-over against the head of the matching queue.
    initial begin
        logic aw_prev = 1'b0;
        w_t w;
        d_t d;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_prev = 1'b0;
                continue;
            end
            if (cmd_valid && cmd_ready) accept_cyc = cyc;
            if (awvalid) begin
                if (exp_aw.size() == 0) begin
                    check("aw_unexpected", 64'(awvalid), 0);
                end else begin
                    check("awaddr", 64'(awaddr), 64'(exp_aw[0].addr));
                    check("awlen", 64'(awlen), 64'(exp_aw[0].len));
                    check("awsize", 64'(awsize), 64'(exp_aw[0].size));
                    check("awburst", 64'(awburst), 64'(exp_aw[0].burst));
                    if (!aw_prev) check("aw_latency", 64'(cyc), 64'(accept_cyc + 1));
                    if (awready) void'(exp_aw.pop_front());
                end
            end
            aw_prev = awvalid && !awready;
            if (wvalid && wready) begin
                if (exp_w.size() == 0) begin
                    check("w_unexpected", 64'(wvalid), 0);
                end else begin
                    check("w_before_aw", 64'(exp_aw.size()), 0);
                    w = exp_w.pop_front();
                    check("wdata", 64'(wdata), 64'(w.data));
                    check("wstrb", 64'(wstrb), 64'(w.strb));
                    check("wlast", 64'(wlast), 64'(w.last));
                end
            end
            if (bvalid && bready) b_cyc = cyc;
            if (cyc == ready_chk) check("cmd_ready_after_done", 64'(cmd_ready), 1);
            if (done) begin
                if (exp_d.size() == 0) begin
                    check("done_unexpected", 64'(done), 0);
                end else begin
                    d = exp_d.pop_front();
                    check("done_resp", 64'(done_resp), 64'(d.resp));
                    if (d.illegal) begin
                        check("err_latency", 64'(cyc), 64'(accept_cyc + 1));
                    end else begin
                        check("done_latency", 64'(cyc), 64'(b_cyc + 1));
                        check("beats_left", 64'(exp_w.size()), 0);
                    end
                    ready_chk = cyc + 1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
        errors++;
        finish_run();
    end

    initial begin
        int unsigned wl[4] = '{1, 3, 7, 15};
        int unsigned r, burst, size, len, a;
        rst = 1'b1;
        wr_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awvalid", 64'(awvalid), 0);
        check("rst_wvalid", 64'(wvalid), 0);
        check("rst_bready", 64'(bready), 0);
        check("rst_done", 64'(done), 0);
        check("rst_done_resp", 64'(done_resp), 0);
        check("rst_wlast", 64'(wlast), 0);
        check("rst_wstrb", 64'(wstrb), 0);
        check("rst_cmd_ready", 64'(cmd_ready), 0);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        send_cmd(32'h100, 3, 2, 1, 2'b00, 0, -1);
        send_cmd(32'h002, 2, 0, 1, 2'b00, 0, -1);
        send_cmd(32'h018, 3, 2, 2, 2'b00, 0, -1);
        send_cmd(32'h018, 2, 2, 2, 2'b00, 0, -1);
        send_cmd(32'hFF8, 3, 2, 1, 2'b00, 0, -1);
        send_cmd(32'h040, 3, 2, 3, 2'b00, 0, -1);
        aw_dly = 5;
        wr_pct = 50;
        b_dly = 3;
        send_cmd(32'h204, 7, 2, 1, 2'b10, 3, -1);
        aw_dly = 0;
        wr_pct = 100;
        b_dly = 0;
        send_cmd(32'h100, 3, 2, 1, 2'b00, 0, 2);
        send_cmd(32'h100, 3, 2, 1, 2'b00, 0, -1);

        repeat (60) begin
            r = $urandom_range(9, 0);
            burst = (r < 2) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
            size = $urandom_range(3, 0);
            len = $urandom_range(15, 0);
            if (burst == 2 && $urandom_range(4, 0) != 0) len = wl[$urandom_range(3, 0)];
            a = $urandom_range(32'h1FFF, 0);
            if (burst == 2 && $urandom_range(3, 0) != 0) a = a & ~((32'd1 << size) - 1);
            if (burst == 1 && $urandom_range(4, 0) == 0) a = 32'h0FC0 + $urandom_range(63, 0);
            aw_dly = int'($urandom_range(3, 0));
            wr_pct = int'($urandom_range(100, 40));
            b_dly = int'($urandom_range(3, 0));
            send_cmd(a, len, size, burst, 2'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                     -1);
        end

        repeat (5) @(posedge clk);
        check("queues_drained", 64'(exp_aw.size() + exp_w.size() + exp_d.size()), 0);
        finish_run();
    end

endmodule

// File: doc/axi_wr_master.md
Name: axi_wr_master

Overview:
AXI4 write-channel initiator (manager) that drives the AW/W/B channels of axi_dpmem or any AXI4 write subordinate.
- Accepts one burst command at a time and validates it against AXI4 burst rules.
- Issues AW, streams user data onto W with block-generated WSTRB/WLAST, and reports BRESP on a one-cycle done pulse.
- Used by bench traffic generators and on-chip DMA-style clients.

Parameters:
ADDR_WIDTH, 32, address width (AXI_ADDR_WIDTH).
DATA_WIDTH, 32, data width in bits; power of 2, 8..1024.
STRB_WIDTH, DATA_WIDTH/8, byte lanes; derived, do not override.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_addr  in  ADDR_WIDTH  start address, may be unaligned
cmd_len  in  8  beats-1 (AXI len_t)
cmd_size  in  3  bytes/beat = 1<<cmd_size (size_enum_t)
cmd_burst  in  2  FIXED/INCR/WRAP/RESERVED (burst_enum_t)
wr_data  in  DATA_WIDTH  beat data, already lane-positioned
wr_valid  in  1  beat valid
wr_ready  out  1  beat consumed when wr_valid&wr_ready
done  out  1  one-cycle completion pulse
done_resp  out  2  burst response, held until next done
awaddr/awlen/awsize/awburst  out  ADDR_WIDTH/8/3/2  AW payload, equal to latched command
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  DATA_WIDTH  = wr_data
wstrb  out  STRB_WIDTH  generated byte strobes
wlast  out  1  high on final beat
wvalid  out  1  W valid
wready  in  1  W ready
bresp  in  2  write response
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- Reset: state IDLE. awvalid, wvalid, bready, done, done_resp, wlast and wstrb are 0 from the first edge with rst high. cmd_ready=0 while rst is high.
- cmd_ready = (state==IDLE) && !rst. Command fields are latched on acceptance (cycle N).
- Legality check on accepted command. Illegal if any of:
  - burst==RESERVED
  - size > log2(STRB_WIDTH)
  - WRAP with len not in {1,3,7,15}
  - WRAP with addr not size-aligned
  - INCR with (addr[11:0] & ~(2^size-1)) + ((len+1)<<size) > 4096
- Illegal command: state ERR; done=1 with done_resp=2'b10 at N+1; no AXI traffic; return to IDLE.
- AW state: awvalid=1 from N+1 until awready. Payload is stable while awvalid is high (AXI rule) and awaddr is the unaligned cmd_addr. No W beat is accepted before the AW handshake completes.
- W state: wvalid=wr_valid, wr_ready=wready (combinational pass-through), wdata=wr_data.
  - beat_cnt starts at 0 and increments on each wvalid&wready.
  - wlast = (beat_cnt==len).
  - The W handshake on the last beat moves the state to B.
- Beat address (internal):
  - beat 0 = addr; al = addr & ~(2^size-1).
  - FIXED: unchanged.
  - INCR: al + 2^size.
  - WRAP: with bound=(len+1)<<size, next = (addr & ~(bound-1)) | ((addr+2^size) & (bound-1)).
- wstrb: with lane = beat_addr mod STRB_WIDTH and alane = al mod STRB_WIDTH, bit i = 1 iff lane <= i < alane + 2^size.
- B state: bready=1. On bvalid, bresp is latched; the next cycle gives done=1 and done_resp=bresp, then state returns to IDLE.
- Latency and throughput:
  - Earliest legal completion: AW at N+1, one beat per cycle, B in the cycle after the last W, done the cycle after B.
  - cmd_ready returns high the cycle after done.
- Reset mid-burst aborts with no done pulse. Partial bursts are not completed (bench responsibility).

Test Plan:
1. INCR addr=0x100 len=3 size=2, all readies high, bresp=00 -> awaddr=0x100 awlen=3 awsize=2 awburst=01; 4 beats wstrb=0xF, wlast on beat 4; done=1 with done_resp=00.
2. Narrow INCR addr=0x2 len=2 size=0 -> wstrb 0x4,0x8,0x1; wlast on beat 3.
3. WRAP addr=0x18 len=3 size=2 -> beat addrs 0x18,0x1C,0x10,0x14, wstrb 0xF each. Then WRAP len=2 -> done_resp=10 at N+1, awvalid never high.
4. INCR addr=0xFF8 len=3 size=2 (4KB crossing), and separately burst=11 -> each: done_resp=10, no AW/W activity.
5. awready low 5 cycles; random wready and wr_valid gaps; bresp=10 -> awvalid and payload stable until handshake, exactly len+1 beats, done_resp=10.
6. rst for 1 cycle after 2 of 4 beats -> next cycle awvalid=wvalid=bready=done=0, cmd_ready=1, no done pulse. A following test 1 command completes normally.
